// File: rtl/tick_stopwatch_if.sv
// Result-side bus of tick_stopwatch: captured count, statistics and the
// valid/ack handshake toward the register bus.
interface tick_stopwatch_if #(
  parameter int W  = 32,
  parameter int NW = 16
);
  logic          ack;
  logic [W-1:0]  result;
  logic          result_sat;
  logic          result_valid;
  logic          overrun;
  logic [W-1:0]  min_result;
  logic [W-1:0]  max_result;
  logic [NW-1:0] n_meas;

  modport master (
    input  ack,
    output result, result_sat, result_valid, overrun,
    output min_result, max_result, n_meas
  );

  modport slave (
    output ack,
    input  result, result_sat, result_valid, overrun,
    input  min_result, max_result, n_meas
  );
endinterface

// File: rtl/tick_stopwatch.sv
// Counts timer_tick pulses between start and stop, captures the count and
// keeps min/max/number-of-measurement statistics behind a valid/ack handshake.
module tick_stopwatch #(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic         timer_tick,
  input  logic         clear,
  output logic         busy,
  output logic [W-1:0] elapsed,
  tick_stopwatch_if.master bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0]  CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] N_ONE   = {{(NW-1){1'b0}}, 1'b1};

  // Returns {blocked, value}; blocked flags an increment lost to saturation.
  function automatic logic [W:0] sat_inc(input logic [W-1:0] v, input logic inc);
    if (!inc)
      return {1'b0, v};
    else if (&v)
      return {1'b1, v};
    else
      return {1'b0, v + CNT_ONE};
  endfunction

  state_t       state;
  logic         sat;
  logic [W:0]   inc_res;
  logic [W-1:0] cnt_nxt;
  logic         blk;
  logic         capture;
  logic         sat_nxt;

  always_comb begin
    inc_res = sat_inc(elapsed, timer_tick);
    cnt_nxt = inc_res[W-1:0];
    blk     = inc_res[W];
    sat_nxt = sat | blk;
    capture = (state == RUN) && stop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      busy             <= 1'b0;
      elapsed          <= '0;
      sat              <= 1'b0;
      bus.result       <= '0;
      bus.result_sat   <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.min_result   <= '1;
      bus.max_result   <= '0;
      bus.n_meas       <= '0;
    end else if (clear) begin
      state            <= IDLE;
      busy             <= 1'b0;
      elapsed          <= '0;
      sat              <= 1'b0;
      bus.result       <= '0;
      bus.result_sat   <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.min_result   <= '1;
      bus.max_result   <= '0;
      bus.n_meas       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            elapsed <= '0;
            sat     <= 1'b0;
          end
        end
        RUN: begin
          // A start (with or without stop) re-arms the count and stays in RUN.
          if (start) begin
            elapsed <= '0;
            sat     <= 1'b0;
          end else begin
            elapsed <= cnt_nxt;
            sat     <= sat_nxt;
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Capture takes precedence over a same-cycle ack.
      if (capture) begin
        bus.result       <= cnt_nxt;
        bus.result_sat   <= sat_nxt;
        bus.result_valid <= 1'b1;
        if (bus.result_valid && !bus.ack)
          bus.overrun <= 1'b1;
        if (cnt_nxt < bus.min_result)
          bus.min_result <= cnt_nxt;
        if (cnt_nxt > bus.max_result)
          bus.max_result <= cnt_nxt;
        if (!(&bus.n_meas))
          bus.n_meas <= bus.n_meas + N_ONE;
      end else if (bus.ack) begin
        bus.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed bench for tick_stopwatch: stimulus pushes expected captures into
// queues, monitors pop and compare whenever n_meas advances.
module tb_tick_stopwatch;

  typedef struct {
    logic [15:0] res;
    logic        sat;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] n;
    logic        ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        timer_tick = 1'b0;
  logic        clear = 1'b0;
  logic        en4 = 1'b0;
  logic        start4;
  logic        busy, busy4;
  logic [15:0] elapsed;
  logic [3:0]  elapsed4;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  exp_t q4[$];

  tick_stopwatch_if #(.W(16), .NW(16)) bus ();
  tick_stopwatch_if #(.W(4),  .NW(4))  bus4 ();

  assign start4 = start & en4;

  tick_stopwatch #(.W(16), .NW(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .timer_tick(timer_tick),
    .clear(clear), .busy(busy), .elapsed(elapsed), .bus(bus)
  );

  tick_stopwatch #(.W(4), .NW(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .stop(stop), .timer_tick(timer_tick),
    .clear(clear), .busy(busy4), .elapsed(elapsed4), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic tk, input logic cl, input logic ak);
    start      = st;
    stop       = sp;
    timer_tick = tk;
    clear      = cl;
    bus.ack    = ak;
    bus4.ack   = ak;
    @(posedge clk);
    #1;
  endtask

  // start, k ticking RUN cycles, then stop with no tick
  task automatic measure(input int k);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < k; i++) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  task automatic push(input logic [15:0] r, input logic s, input logic [15:0] mn,
                      input logic [15:0] mx, input logic [15:0] n, input logic o);
    exp_t e;
    e.res = r; e.sat = s; e.mn = mn; e.mx = mx; e.n = n; e.ovr = o;
    q.push_back(e);
  endtask

  task automatic push4(input logic [15:0] r, input logic s, input logic [15:0] mn,
                       input logic [15:0] mx, input logic [15:0] n, input logic o);
    exp_t e;
    e.res = r; e.sat = s; e.mn = mn; e.mx = mx; e.n = n; e.ovr = o;
    q4.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_elapsed"},  32'(elapsed), 0);
    chk({tag, "_result"},   32'(bus.result), 0);
    chk({tag, "_rsat"},     32'(bus.result_sat), 0);
    chk({tag, "_rvalid"},   32'(bus.result_valid), 0);
    chk({tag, "_overrun"},  32'(bus.overrun), 0);
    chk({tag, "_n_meas"},   32'(bus.n_meas), 0);
    chk({tag, "_min"},      32'(bus.min_result), 32'h0000FFFF);
    chk({tag, "_max"},      32'(bus.max_result), 0);
  endtask

  // Monitor for the W=16 instance
  logic [15:0] prev_n = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.n_meas == prev_n + 16'd1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_capture: got result %0d expected no capture", bus.result);
      end else begin
        e = q.pop_front();
        chk("cap_result",  32'(bus.result), 32'(e.res));
        chk("cap_sat",     32'(bus.result_sat), 32'(e.sat));
        chk("cap_valid",   32'(bus.result_valid), 1);
        chk("cap_min",     32'(bus.min_result), 32'(e.mn));
        chk("cap_max",     32'(bus.max_result), 32'(e.mx));
        chk("cap_n",       32'(bus.n_meas), 32'(e.n));
        chk("cap_overrun", 32'(bus.overrun), 32'(e.ovr));
      end
    end
    prev_n = bus.n_meas;
  end

  // Monitor for the W=4 instance
  logic [3:0] prev4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus4.n_meas == prev4 + 4'd1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_capture4: got result %0d expected no capture", bus4.result);
      end else begin
        e = q4.pop_front();
        chk("cap4_result",  32'(bus4.result), 32'(e.res));
        chk("cap4_sat",     32'(bus4.result_sat), 32'(e.sat));
        chk("cap4_min",     32'(bus4.min_result), 32'(e.mn));
        chk("cap4_max",     32'(bus4.max_result), 32'(e.mx));
        chk("cap4_n",       32'(bus4.n_meas), 32'(e.n));
        chk("cap4_overrun", 32'(bus4.overrun), 32'(e.ovr));
      end
    end
    prev4 = bus4.n_meas;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ack  = 1'b0;
    bus4.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rstn = 1'b1;
    step(0, 0, 0, 0, 0);

    // 10 ticks over 25 cycles, no tick on stop
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 0, (i < 20) && (i % 2 == 0), 0, 0);
    push(10, 0, 10, 10, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_rvalid", 32'(bus.result_valid), 1);
    step(0, 0, 0, 0, 1);
    chk("t1_ack_rvalid", 32'(bus.result_valid), 0);

    // tick held high, stop 5 cycles after start
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    push(5, 0, 5, 10, 2, 0);
    step(0, 1, 1, 0, 0);
    chk("t2_rvalid", 32'(bus.result_valid), 1);
    step(0, 0, 0, 0, 1);
    chk("t2_ack_rvalid", 32'(bus.result_valid), 0);

    // three unacked measurements, then clear
    step(0, 0, 0, 1, 0);
    chk("t3_clear_n", 32'(bus.n_meas), 0);
    push(7, 0, 7, 7, 1, 0);
    measure(7);
    push(3, 0, 3, 7, 2, 1);
    measure(3);
    push(12, 0, 3, 12, 3, 1);
    measure(12);
    chk("t3_overrun", 32'(bus.overrun), 1);
    step(0, 0, 0, 1, 0);
    chk_reset_state("t3_clear");

    // start+stop in RUN, then start+stop in IDLE
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    push(5, 0, 5, 5, 1, 0);
    step(1, 1, 1, 0, 0);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_elapsed", 32'(elapsed), 0);
    push(0, 0, 0, 5, 2, 1);
    step(0, 1, 0, 0, 0);
    chk("t5_idle", 32'(busy), 0);
    step(1, 1, 0, 0, 0);
    chk("t5_idle_ss_busy", 32'(busy), 1);
    chk("t5_idle_ss_n", 32'(bus.n_meas), 2);
    push(0, 0, 0, 5, 3, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t5_ack_rvalid", 32'(bus.result_valid), 0);

    // capture coinciding with ack
    step(0, 0, 0, 1, 0);
    push(2, 0, 2, 2, 1, 0);
    measure(2);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    push(3, 0, 2, 3, 2, 0);
    step(0, 1, 0, 0, 1);
    chk("t6_rvalid", 32'(bus.result_valid), 1);
    chk("t6_overrun", 32'(bus.overrun), 0);

    // asynchronous reset mid-RUN
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("t7_pre_busy", 32'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_elapsed", 32'(elapsed), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("t7_wait_busy", 32'(busy), 0);
    chk("t7_wait_elapsed", 32'(elapsed), 0);
    chk("t7_n", 32'(bus.n_meas), 0);

    // saturation on the W=4 instance (main instance sees the same pulses)
    en4 = 1'b1;
    push(20, 0, 20, 20, 1, 0);
    push4(15, 1, 15, 15, 1, 0);
    measure(20);
    push(2, 0, 2, 20, 2, 1);
    push4(2, 0, 2, 15, 2, 1);
    measure(2);
    en4 = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    chk("pending_q", 32'(q.size()), 0);
    chk("pending_q4", 32'(q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

Measures elapsed `timer_tick` pulses between a `start` and a `stop` event and accumulates statistics over successive measurements. It is the measuring counterpart of the down-counting timer: the timer generates intervals, and this block reads them back as counts. Results go to the register bus through a valid/ack handshake, with sticky overrun and saturation flags. It sits in the same clock domain as the tick generator, typically next to the trigger/timer logic in the FPGA fabric.

## Interface
Parameters:
- `W`, default 32: width of count, result, min and max.
- `NW`, default 16: width of the measurement counter.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a measurement (one-cycle pulse or level; sampled every cycle).
- `stop`  in  1  end the measurement and capture the result.
- `timer_tick`  in  1  count enable; one increment per cycle when high.
- `clear`  in  1  synchronous clear of the measurement and all statistics.
- `ack`  in  1  consumer acknowledges `result`.
- `busy`  out  1  high in RUN.
- `elapsed`  out  W  live count of the current or last measurement.
- `result`  out  W  last captured count.
- `result_sat`  out  1  the captured measurement saturated.
- `result_valid`  out  1  `result` is unread; a level held until `ack`.
- `overrun`  out  1  sticky: a capture overwrote an unacked result.
- `min_result`  out  W  smallest captured result since reset or clear.
- `max_result`  out  W  largest captured result since reset or clear.
- `n_meas`  out  NW  number of captures since reset or clear; saturates at all-ones.

## Operation
States are IDLE and RUN.

IDLE:
- `start`=1 goes to RUN, `count`=0, `sat`=0.
- A tick in the start cycle is not counted.
- `stop` is ignored.

RUN:
- Each cycle: `count` = `count` + `timer_tick`, saturating at 2^W−1.
- `sat` is set when an increment is blocked by saturation, and stays set until the next start.
- `stop`=1 captures:
  - `result` = `count` + `timer_tick` (saturating), so a tick in the stop cycle is included.
  - `result_sat` = the saturation state including that tick.
  - Returns to IDLE.
- `start`=1 without `stop` restarts: `count`=0, `sat`=0, no capture.
- `start`=1 with `stop`=1 (back-to-back): the capture happens as above, then the block restarts and stays in RUN with `count`=0.

On every capture:
- `result_valid`=1.
- If `result_valid` was already 1 and `ack`=0 in the same cycle, `overrun`=1.
- `min_result` = min(`min_result`, new), `max_result` = max(`max_result`, new), both unsigned.
- `n_meas` increments unless it is all-ones.

Handshake:
- `ack`=1 while `result_valid`=1 clears `result_valid` on the next edge.
- A capture and `ack` in the same cycle: the capture wins, `result_valid` stays 1, and `overrun` is not set.
- `ack` while `result_valid`=0 is ignored.

`clear` has top priority. It forces IDLE and resets `count`, `sat`, `result`, `result_sat`, `result_valid`, `overrun`, `n_meas` and the min/max to their reset values, overriding `start`, `stop` and `ack` in the same cycle.

`elapsed` shows `count`. In IDLE it holds the last value until a start or clear.

## Timing
- Reset values (`rstn`=0, asynchronous):
  - state IDLE, `busy`=0.
  - `elapsed`=0, `result`=0, `result_sat`=0, `result_valid`=0, `overrun`=0, `n_meas`=0.
  - `min_result`=2^W−1, `max_result`=0.
- All outputs are registered. No combinational path from inputs to outputs.
- `busy` rises on the edge that samples `start`.
- `result`, `result_valid`, min, max and `n_meas` update on the edge that samples `stop`, so they are visible in the cycle after `stop`.
- `result_valid` falls on the edge that samples `ack`.
- The block accepts a capture every cycle; back-to-back stops with ticks held high yield results of 1.
- Reset asserted mid-measurement aborts it immediately with no capture. After release, the block waits in IDLE for `start`.

## Test plan
- Start, then 10 ticks spread over 25 cycles, with no tick on the stop cycle -> `result`=10, `result_valid`=1 one cycle after stop, `n_meas`=1, `min_result`=`max_result`=10, `busy`=0.
- `timer_tick` held high, start at t0 with stop 5 cycles later (tick high in both the start and stop cycles) -> `result`=5. Then `ack` -> `result_valid`=0 on the next cycle.
- Three measurements of 7, 3 and 12 ticks with no ack -> `result`=12, `overrun`=1, `min_result`=3, `max_result`=12, `n_meas`=3. Then `clear` -> all outputs return to reset values.
- W=4, ticks held high for 20 cycles, then stop -> `result`=15, `result_sat`=1. A following 2-tick measurement -> `result`=2, `result_sat`=0.
- `start`+`stop` in the same cycle in RUN after 4 ticks -> `result`=4 (5 if a tick is high in that cycle), `busy` stays 1, and `elapsed`=0 in the next cycle. `start`+`stop` in IDLE -> RUN with no capture.
- `rstn` pulsed low mid-RUN -> `busy`=0 and `elapsed`=0 immediately, with no capture. Capture coinciding with `ack` while `result_valid`=1 -> `result_valid` stays 1 and `overrun` stays 0.
